// File: rtl/wb_write_buffer.sv
// Writeback buffer: a small FIFO of pending register-file writes that drains
// into the register file and forwards the youngest pending value to decode.
module wb_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [31:0]              rf_data,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     byp_hit_s,
    output logic                     byp_hit_t,
    output logic [31:0]              byp_data_s,
    output logic [31:0]              byp_data_t,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    mem_rd   [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    // Writes to x0 complete the handshake but are dropped here.
    assign push     = in_valid && in_ready && (in_rd != 5'd0);
    assign rf_we    = !empty && !rf_stall;
    assign pop      = rf_we;
    assign rf_rd    = empty ? 5'd0  : mem_rd[head];
    assign rf_data  = empty ? 32'd0 : mem_data[head];

    // Pointer and occupancy bookkeeping; both pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are never cleared, validity comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[tail]   <= in_rd;
            mem_data[tail] <= in_data;
        end
    end

    // Scan stored entries oldest to youngest so the youngest match wins.
    always_comb begin
        byp_hit_s  = 1'b0;
        byp_hit_t  = 1'b0;
        byp_data_s = 32'd0;
        byp_data_t = 32'd0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (rs != 5'd0 && mem_rd[head + AW'(k)] == rs) begin
                    byp_hit_s  = 1'b1;
                    byp_data_s = mem_data[head + AW'(k)];
                end
                if (rt != 5'd0 && mem_rd[head + AW'(k)] == rt) begin
                    byp_hit_t  = 1'b1;
                    byp_data_t = mem_data[head + AW'(k)];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed bench for wb_write_buffer: expected rf writes go into a queue
// that a negedge monitor drains; state and bypass are checked inline.
module tb_wb_write_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        rf_stall;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        byp_hit_s;
    logic        byp_hit_t;
    logic [31:0] byp_data_s;
    logic [31:0] byp_data_t;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    wb_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data),
        .rf_stall(rf_stall), .rf_we(rf_we),
        .rf_rd(rf_rd), .rf_data(rf_data),
        .rs(rs), .rt(rt),
        .byp_hit_s(byp_hit_s), .byp_hit_t(byp_hit_t),
        .byp_data_s(byp_data_s), .byp_data_t(byp_data_t),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd,
                         input logic [31:0] d, input logic expect_wr);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        if (expect_wr) exp_q.push_back('{rd: rd, data: d});
    endtask

    // Monitor: every cycle the DUT writes the register file must match the
    // oldest expected write.
    always @(negedge clk) begin
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rf_write_rd", {27'd0, rf_rd}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
                chk("rf_data", rf_data, e.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_rd = 5'd0;
        in_data = 32'd0;
        rf_stall = 1'b0;
        rs = 5'd0;
        rt = 5'd0;

        // Reset state
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_count", count, 0);
        chk("rst_rf_data", rf_data, 0);
        tick();
        rst = 1'b0;

        // Single write, one-cycle latency
        drive(1, 5'd5, 32'hDEAD_BEEF, 1);
        @(negedge clk);
        chk("single_ready", in_ready, 1);
        chk("single_we_early", rf_we, 0);
        tick();
        drive(0, 5'd0, 32'd0, 0);
        @(negedge clk);
        chk("single_we", rf_we, 1);
        chk("single_rd", rf_rd, 5);
        tick();
        @(negedge clk);
        chk("single_empty", empty, 1);
        chk("single_we_after", rf_we, 0);

        // Fill under stall; fifth request must be refused
        for (int i = 1; i <= 5; i++) begin
            tick();
            rf_stall = 1'b1;
            drive(1, 5'(i), 32'(i * 32'h11), i <= 4);
            @(negedge clk);
            chk("fill_ready", in_ready, (i <= 4) ? 1 : 0);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0);
        rs = 5'd3;
        @(negedge clk);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        chk("fill_we_stalled", rf_we, 0);
        chk("fill_byp_hit", byp_hit_s, 1);
        chk("fill_byp_data", byp_data_s, 32'h33);
        tick();
        rf_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("drain_we", rf_we, 1);
            chk("drain_rd", rf_rd, k);
            tick();
        end
        @(negedge clk);
        chk("drain_empty", empty, 1);

        // Bypass priority, same-cycle invisibility, popped-entry visibility
        tick();
        rf_stall = 1'b1;
        rs = 5'd7;
        rt = 5'd3;
        drive(1, 5'd7, 32'hA, 1);
        @(negedge clk);
        chk("byp_not_yet", byp_hit_s, 0);
        tick();
        drive(1, 5'd7, 32'hB, 1);
        @(negedge clk);
        chk("byp_old_only", byp_data_s, 32'hA);
        tick();
        drive(0, 5'd0, 32'd0, 0);
        @(negedge clk);
        chk("byp_hit_s", byp_hit_s, 1);
        chk("byp_data_s", byp_data_s, 32'hB);
        chk("byp_hit_t", byp_hit_t, 0);
        chk("byp_data_t", byp_data_t, 0);
        tick();
        rf_stall = 1'b0;
        @(negedge clk);
        chk("byp_pop1_data", byp_data_s, 32'hB);
        tick();
        @(negedge clk);
        chk("byp_pop2_hit", byp_hit_s, 1);
        chk("byp_pop2_data", byp_data_s, 32'hB);
        tick();
        @(negedge clk);
        chk("byp_gone", byp_hit_s, 0);

        // Zero register discarded
        tick();
        rs = 5'd0;
        rt = 5'd0;
        drive(1, 5'd0, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        chk("zero_ready", in_ready, 1);
        tick();
        drive(0, 5'd0, 32'd0, 0);
        @(negedge clk);
        chk("zero_count", count, 0);
        chk("zero_we", rf_we, 0);
        chk("zero_byp", byp_hit_s, 0);

        // Wrap: continuous push and pop with one entry in flight
        tick();
        drive(1, 5'd1, 32'h100, 1);
        for (int i = 1; i <= 3 * DEPTH; i++) begin
            tick();
            drive(1, 5'((i % 31) + 1), 32'h100 + 32'(i), 1);
            @(negedge clk);
            chk("wrap_count", count, 1);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0);
        tick();
        @(negedge clk);
        chk("wrap_empty", empty, 1);

        // Reset mid-operation drops pending entries
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1, 5'(10 + i), 32'hA0 + 32'(i), 0);
        end
        tick();
        drive(0, 5'd0, 32'd0, 0);
        rs = 5'd11;
        @(negedge clk);
        chk("prerst_count", count, 3);
        chk("prerst_byp", byp_hit_s, 1);
        #2;
        rst = 1'b1;
        rf_stall = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_we", rf_we, 0);
        chk("midrst_rf_rd", rf_rd, 0);
        chk("midrst_byp", byp_hit_s, 0);
        chk("midrst_byp_data", byp_data_s, 0);
        chk("midrst_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_we", rf_we, 0);
            tick();
        end

        chk("scoreboard_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
